// File: rtl/pipe_datapath_memory_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Holds the access-size decode, the funct3 codes and the request FSM states.
package pipe_datapath_memory_lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    // The low two funct3 bits give the size; bit 2 only selects zero-extension.
    function automatic access_size_e size_of(input logic [2:0] funct3);
        case (funct3 & 3'b011)
            F3_LB:   size_of = SZ_BYTE;
            F3_LH:   size_of = SZ_HALF;
            default: size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_illegal_f3(input logic [2:0] funct3);
        is_illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/pipe_datapath_memory_lsu_load_extend.sv
// Load lane extraction: picks the byte/half addressed by addr_lo out of the
// memory word and sign- or zero-extends it to XLEN.
module pipe_load_extend
    import pipe_datapath_memory_lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        zero_ext;

    // NOTE: every signal gets a default at the top of a combinational block so no path infers a latch.
    always_comb begin
        byte_sel = word[7:0];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        zero_ext = funct3[2];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase

        case (size_of(funct3))
            SZ_BYTE: data = zero_ext ? {{(XLEN-8){1'b0}}, byte_sel}
                                     : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            SZ_HALF: data = zero_ext ? {{(XLEN-16){1'b0}}, half_sel}
                                     : {{(XLEN-16){half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/pipe_datapath_memory_lsu.sv
// RV32I memory stage with MEM/WB register: issues req/ack data-memory accesses,
// stalls M and earlier while an access is outstanding, and retires into W.
module pipe_datapath_memory_lsu
    import pipe_datapath_memory_lsu_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1,
    parameter int RD_W           = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_dp_validM,
    input  logic            i_dp_MemReadM,
    input  logic            i_dp_MemWriteM,
    input  logic [2:0]      i_dp_funct3M,
    input  logic [XLEN-1:0] i_dp_AddrM,
    input  logic [XLEN-1:0] i_dp_WriteDataM,
    input  logic [XLEN-1:0] i_dp_4to1muxM,
    input  logic            i_dp_ResultSrcM,
    input  logic            i_dp_RegWriteM,
    input  logic [RD_W-1:0] i_dp_RdM,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_dp_stallM,
    output logic            o_dp_validW,
    output logic [XLEN-1:0] o_dp_ReadDataW,
    output logic [XLEN-1:0] o_dp_4to1muxW,
    output logic            o_dp_ResultSrcW,
    output logic            o_dp_RegWriteW,
    output logic [RD_W-1:0] o_dp_RdW,
    output logic            o_dp_excW
);

    lsu_state_e      state, state_next;
    access_size_e    size;
    logic            memop;
    logic            misaligned;
    logic            exc;
    logic            access;
    logic [1:0]      lane;
    logic [XLEN-1:0] load_data;

    // Access decode: size, misalignment and the (possibly force-aligned) lane offset.
    always_comb begin
        size       = size_of(i_dp_funct3M);
        memop      = i_dp_validM && (i_dp_MemReadM || i_dp_MemWriteM);
        misaligned = is_illegal_f3(i_dp_funct3M);
        lane       = 2'b00;
        case (size)
            SZ_BYTE: lane = i_dp_AddrM[1:0];
            SZ_HALF: begin
                lane       = {i_dp_AddrM[1], 1'b0};
                misaligned = misaligned || i_dp_AddrM[0];
            end
            default: misaligned = misaligned || (i_dp_AddrM[1:0] != 2'b00);
        endcase
        exc    = MISALIGN_CHECK && memop && misaligned && (state == ST_IDLE);
        access = memop && !exc;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (access && !i_dmem_ack) state_next = ST_WAIT;
            ST_WAIT: if (i_dmem_ack)            state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    // Reset gates req combinationally so a pending request drops in the reset cycle itself.
    always_comb begin
        o_dmem_req   = !i_rst && ((state == ST_WAIT) || ((state == ST_IDLE) && access));
        o_dp_stallM  = o_dmem_req && !i_dmem_ack;
        o_dmem_we    = o_dmem_req && i_dp_MemWriteM;
        o_dmem_addr  = {i_dp_AddrM[XLEN-1:2], 2'b00};
        o_dmem_be    = 4'b0000;
        o_dmem_wdata = '0;
        if (o_dmem_req) begin
            case (size)
                SZ_BYTE: o_dmem_be = 4'b0001 << lane;
                SZ_HALF: o_dmem_be = 4'b0011 << lane;
                default: o_dmem_be = 4'b1111;
            endcase
        end
        if (o_dmem_we) begin
            case (size)
                SZ_BYTE: o_dmem_wdata = {4{i_dp_WriteDataM[7:0]}};
                SZ_HALF: o_dmem_wdata = {2{i_dp_WriteDataM[15:0]}};
                default: o_dmem_wdata = i_dp_WriteDataM;
            endcase
        end
    end

    pipe_load_extend u_load_extend (
        .funct3  (i_dp_funct3M),
        .addr_lo (lane),
        .word    (i_dmem_rdata),
        .data    (load_data)
    );

    // MEM/WB register: never stalls; a held or empty M stage becomes a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst || o_dp_stallM || !i_dp_validM) begin
            o_dp_validW     <= 1'b0;
            o_dp_ReadDataW  <= '0;
            o_dp_4to1muxW   <= '0;
            o_dp_ResultSrcW <= 1'b0;
            o_dp_RegWriteW  <= 1'b0;
            o_dp_RdW        <= '0;
            o_dp_excW       <= 1'b0;
        end else begin
            o_dp_validW     <= 1'b1;
            o_dp_ReadDataW  <= (o_dmem_req && i_dmem_ack && i_dp_MemReadM) ? load_data : '0;
            o_dp_4to1muxW   <= i_dp_4to1muxM;
            o_dp_ResultSrcW <= i_dp_ResultSrcM;
            o_dp_RegWriteW  <= i_dp_RegWriteM && !exc;
            o_dp_RdW        <= i_dp_RdM;
            o_dp_excW       <= exc;
        end
    end

endmodule
